// File: rtl/aes_round_engine.sv
// Purpose : iterative AES-128/192/256 encryption core; one 128-bit state register reused for every round.
// Latency : ciphertext valid NR+1 cycles after the accept cycle (2*NR+1 with PIPE_SB=1).
// Backpressure: result is held in DONE until out_ready; no new block is accepted until the result is taken.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    plaintext handshake; din[127:96] is column 0, byte 0 in the MSBs
//   rk_idx/rk_in         round-key index (registered) and the key returned combinationally by the store
//   out_valid/out_ready  ciphertext handshake; dout uses the same byte order as din
//   busy                 high whenever the engine is not idle

// S-box substitution of one 32-bit column (four bytes).
module aes_sub_word (
    input  logic [31:0] col,
    output logic [31:0] sub
);

    // Table row n holds S(16n) .. S(16n+15), first entry in the MSBs.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x sits at bits [2047-8x -: 8]; 2047-8x is simply {~x, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b111} -: 8];
    endfunction

    assign sub = {sbox(col[31:24]), sbox(col[23:16]), sbox(col[15:8]), sbox(col[7:0])};

endmodule

// MixColumns transform of one 32-bit column (byte 0 in the MSBs).
module aes_mix_col (
    input  logic [31:0] col,
    output logic [31:0] mix
);

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col;

    // Multiplication by 3 is xt(a) ^ a.
    assign mix[31:24] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    assign mix[23:16] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
    assign mix[15:8]  = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
    assign mix[7:0]   = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);

endmodule

module aes_round_engine #(
    parameter int NR      = 10,   // 10, 12 or 14
    parameter int PIPE_SB = 0     // 1: register between SubBytes/ShiftRows and MixColumns/AddRoundKey
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] din,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] dout,
    output logic         busy
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUND   = 2'd1,
        SB_WAIT = 2'd2,
        DONE    = 2'd3
    } fsm_t;

    fsm_t         st, st_nxt;
    logic [3:0]   round;
    logic [127:0] state_q;

    logic [127:0] sb_out;    // SubBytes of state_q
    logic [127:0] sr_out;    // ShiftRows of sb_out
    logic [127:0] mix_src;   // input of the MixColumns/AddRoundKey half
    logic [127:0] mc_out;
    logic [127:0] ark;       // round result after AddRoundKey
    logic         last;      // current round is the final one
    logic         step;      // cycle in which the round result is written back
    logic         accept;

    assign last   = (round == NR_L);
    assign accept = in_valid && (st == IDLE);
    assign step   = (PIPE_SB != 0) ? (st == SB_WAIT) : (st == ROUND);

    // ---------------------------------------------------------------- datapath
    for (genvar c = 0; c < 4; c++) begin : g_sub
        aes_sub_word u_sub (
            .col (state_q[127-32*c -: 32]),
            .sub (sb_out[127-32*c -: 32])
        );
    end

    // Output column c, row j comes from input column (c+j) mod 4, row j.
    always_comb begin
        sr_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) begin
                sr_out[127-32*c-8*j -: 8] = sb_out[127-32*((c+j)%4)-8*j -: 8];
            end
        end
    end

    if (PIPE_SB != 0) begin : g_pipe
        logic [127:0] sb_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sb_q <= '0;
            end else if (st == ROUND) begin
                sb_q <= sr_out;
            end
        end

        assign mix_src = sb_q;
    end else begin : g_nopipe
        assign mix_src = sr_out;
    end

    for (genvar c = 0; c < 4; c++) begin : g_mix
        aes_mix_col u_mix (
            .col (mix_src[127-32*c -: 32]),
            .mix (mc_out[127-32*c -: 32])
        );
    end

    // The final round bypasses MixColumns. round only changes on write-back,
    // so rk_in is the key for the round being finished in both pipe modes.
    assign ark = (last ? mix_src : mc_out) ^ rk_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            round   <= '0;
            dout    <= '0;
        end else begin
            if (accept) begin
                state_q <= din ^ rk_in;        // initial AddRoundKey with key 0
                round   <= 4'd1;
            end else if (step) begin
                state_q <= ark;
                if (last) begin
                    dout <= ark;
                end else begin
                    round <= (round < NR_L) ? round + 4'd1 : NR_L;
                end
            end else if (st == DONE && out_ready) begin
                round <= '0;                   // key 0 requested again while idle
            end
        end
    end

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
        end else begin
            st <= st_nxt;
        end
    end

    always_comb begin
        st_nxt = st;
        case (st)
            IDLE: begin
                if (in_valid) st_nxt = ROUND;
            end
            ROUND: begin
                if (PIPE_SB != 0) st_nxt = SB_WAIT;
                else if (last)    st_nxt = DONE;
            end
            SB_WAIT: begin
                st_nxt = last ? DONE : ROUND;
            end
            DONE: begin
                if (out_ready) st_nxt = IDLE;
            end
            default: st_nxt = IDLE;
        endcase
    end

    // All outputs come from registers, so nothing depends combinationally on rk_in.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rk_idx    = round;
        case (st)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_round_engine.sv
module tb_aes_round_engine;

    localparam logic [127:0] PT       = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192    = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256    = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CT_ZERO  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [255:0] KEY128   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY192   = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] KEY256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] din   [4];
    logic [127:0] rk_in [4];
    logic [127:0] dout  [4];
    logic [3:0]   rk_idx[4];
    logic [127:0] rk_mem[4][16];
    logic [7:0]   sbt[256];

    int n_checks = 0;
    int n_fail   = 0;
    int acc_cnt  = 0;
    int ret_cnt  = 0;
    int ret_bad  = 0;
    logic [127:0] ret_exp = CT128;

    always #5 clk = ~clk;

    // 0: AES-128, 1: AES-192, 2: AES-256, 3: AES-128 with pipelined rounds
    aes_round_engine #(.NR(10), .PIPE_SB(0)) u_nr10 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .din(din[0]),
        .rk_idx(rk_idx[0]), .rk_in(rk_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .dout(dout[0]), .busy(busy[0]));
    aes_round_engine #(.NR(12), .PIPE_SB(0)) u_nr12 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .din(din[1]),
        .rk_idx(rk_idx[1]), .rk_in(rk_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .dout(dout[1]), .busy(busy[1]));
    aes_round_engine #(.NR(14), .PIPE_SB(0)) u_nr14 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .din(din[2]),
        .rk_idx(rk_idx[2]), .rk_in(rk_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .dout(dout[2]), .busy(busy[2]));
    aes_round_engine #(.NR(10), .PIPE_SB(1)) u_pipe (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .din(din[3]),
        .rk_idx(rk_idx[3]), .rk_in(rk_in[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .dout(dout[3]), .busy(busy[3]));

    for (genvar g = 0; g < 4; g++) begin : g_rk
        assign rk_in[g] = rk_mem[g][rk_idx[g]];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // ---------------------------------------------------------- key schedule
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] v = 8'h00;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) v = 8'(y);
            end
        end
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
    endfunction

    task automatic load_keys(input int u, input logic [255:0] key, input int nk);
        logic [31:0] w[60];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        int          nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) begin
            if (r <= nr) rk_mem[u][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else         rk_mem[u][r] = '0;
        end
    endtask

    // ------------------------------------------------ handshake monitor (u_nr10)
    always begin
        @(negedge clk);
        #4;
        if (in_valid[0] && in_ready[0]) acc_cnt++;
        if (out_valid[0] && out_ready[0]) begin
            ret_cnt++;
            if (dout[0] !== ret_exp) ret_bad++;
        end
    end

    // Present one block, then count cycles from the accept cycle until out_valid.
    // rk_idx must read r in round r (held two cycles when pipelined).
    task automatic run_block(input int u, input logic [127:0] pt, input logic [127:0] ct,
                             input int lat, input bit pipe, input string tag);
        int cnt = 0;
        int bad = 0;
        int exp_rk;
        ret_exp = ct;
        @(negedge clk);
        din[u]      = pt;
        in_valid[u] = 1'b1;
        #1;
        check({tag, "_in_ready"}, 128'(in_ready[u]), 128'd1);
        if (rk_idx[u] != 4'd0) bad++;
        do begin
            @(negedge clk);
            in_valid[u] = 1'b0;
            din[u]      = ~pt;          // must not be sampled outside IDLE
            cnt++;
            #1;
            if (!out_valid[u]) begin
                exp_rk = pipe ? (cnt + 1) / 2 : cnt;
                if (int'(rk_idx[u]) != exp_rk) bad++;
            end
        end while (!out_valid[u] && cnt < 200);
        check({tag, "_latency"}, 128'(cnt), 128'(lat));
        check({tag, "_dout"}, dout[u], ct);
        check({tag, "_rk_seq_errors"}, 128'(bad), 128'd0);
    endtask

    task automatic consume(input int u, input string tag);
        @(negedge clk);
        out_ready[u] = 1'b1;
        @(negedge clk);
        out_ready[u] = 1'b0;
        #1;
        check({tag, "_in_ready_after"}, 128'(in_ready[u]), 128'd1);
        check({tag, "_out_valid_after"}, 128'(out_valid[u]), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int a0, r0, b0, k;
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 4; i++) din[i] = '0;
        for (int x = 0; x < 256; x++) sbt[x] = sbox_calc(8'(x));
        load_keys(0, KEY128, 4);
        load_keys(1, KEY192, 6);
        load_keys(2, KEY256, 8);
        load_keys(3, KEY128, 4);

        // reset state
        repeat (2) @(negedge clk);
        for (int u = 0; u < 4; u++) begin
            check("rst_dout", dout[u], 128'd0);
            check("rst_flags", 128'({in_ready[u], out_valid[u], busy[u], rk_idx[u]}), 128'b100_0000);
        end
        rst_n = 1'b1;

        // known-answer runs for every configuration
        run_block(0, PT, CT128, 11, 1'b0, "c1");
        consume(0, "c1");
        run_block(1, PT, CT192, 13, 1'b0, "nr12");
        consume(1, "nr12");
        run_block(2, PT, CT256, 15, 1'b0, "nr14");
        consume(2, "nr14");
        run_block(3, PT, CT128, 21, 1'b1, "pipe");
        consume(3, "pipe");

        // back-pressure: result held, new block refused while DONE
        run_block(0, PT, CT128, 11, 1'b0, "bp");
        a0          = acc_cnt;
        in_valid[0] = 1'b1;
        din[0]      = '0;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("bp_dout_hold", dout[0], CT128);
            check("bp_state", 128'({in_ready[0], out_valid[0], busy[0]}), 128'b011);
        end
        @(negedge clk);
        in_valid[0] = 1'b0;
        #1;
        check("bp_no_accept", 128'(acc_cnt), 128'(a0));
        consume(0, "bp");
        load_keys(0, 256'h0, 4);
        run_block(0, 128'h0, CT_ZERO, 11, 1'b0, "zero");
        consume(0, "zero");

        // asynchronous reset in the middle of a block
        load_keys(0, KEY128, 4);
        @(negedge clk);
        din[0]      = PT;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        k = 0;
        #1;
        while (rk_idx[0] != 4'd5 && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("mid_reached_r5", 128'(rk_idx[0]), 128'd5);
        rst_n = 1'b0;
        #1;
        check("mid_rst_flags", 128'({in_ready[0], out_valid[0], busy[0], rk_idx[0]}), 128'b100_0000);
        check("mid_rst_dout", dout[0], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_block(0, PT, CT128, 11, 1'b0, "post_rst");
        consume(0, "post_rst");

        // in_valid held high with out_ready high: one block per NR+2 cycles
        a0 = acc_cnt;
        r0 = ret_cnt;
        b0 = ret_bad;
        ret_exp = CT128;
        @(negedge clk);
        din[0]       = PT;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b1;
        repeat (36) @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(negedge clk);
        out_ready[0] = 1'b0;
        #1;
        check("stream_accepts", 128'(acc_cnt - a0), 128'd3);
        check("stream_returns", 128'(ret_cnt - r0), 128'd3);
        check("stream_dout_errors", 128'(ret_bad - b0), 128'd0);
        check("stream_idle", 128'({in_ready[0], busy[0]}), 128'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
